// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invflt_pkg.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__invflt_pkg.sv - shared reset constants and counter helper for the glitch-filtering inverter
package gf180mcu_fd_sc_mcu7t5v0__invflt_pkg;

  localparam logic ZN_RST   = 1'b1;
  localparam logic CAND_RST = 1'b0;

  function automatic int sat_inc(input int cnt, input int max);
    return (cnt >= max) ? max : cnt + 1;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invflt_chan.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__invflt_chan.sv - one filtered inverter channel; GF180MCU_FD_SC_MCU7T5V0__INVFLT_SYNC_EN adds a 2-flop input synchronizer
module gf180mcu_fd_sc_mcu7t5v0__invflt_chan
  import gf180mcu_fd_sc_mcu7t5v0__invflt_pkg::*;
#(
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic i,
  output logic zn,
  output logic chg
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES);

  logic             s;
  logic             cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;

`ifdef GF180MCU_FD_SC_MCU7T5V0__INVFLT_SYNC_EN
  logic sync1;
  logic sync2;

  // The synchronizer keeps running while EN is low so its contents stay current.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= i;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = i;
`endif

  always_comb begin
    next_cnt = CNT_MAX;
    if (s != cand) begin
      next_cnt = CNT_W'(1);
    end else begin
      next_cnt = CNT_W'(sat_inc(int'(cnt), FILT_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zn   <= ZN_RST;
      chg  <= 1'b0;
      cand <= CAND_RST;
      cnt  <= CNT_MAX;
    end else if (en) begin
      cand <= s;
      cnt  <= next_cnt;
      if ((next_cnt == CNT_MAX) && (zn != ~s)) begin
        zn  <= ~s;
        chg <= 1'b1;
      end else begin
        chg <= 1'b0;
      end
    end else begin
      chg <= 1'b0;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__invflt_func.sv
// rtl/gf180mcu_fd_sc_mcu7t5v0__invflt_func.sv - multi-channel glitch-filtering inverter top; optional GF180MCU_FD_SC_MCU7T5V0__INVFLT_SYNC_EN input synchronizers
module gf180mcu_fd_sc_mcu7t5v0__invflt_func
  import gf180mcu_fd_sc_mcu7t5v0__invflt_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int FILT_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] ZN,
  output logic [WIDTH-1:0] CHG
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    gf180mcu_fd_sc_mcu7t5v0__invflt_chan #(
      .FILT_CYCLES(FILT_CYCLES)
    ) u_chan (
      .clk(CLK),
      .rst(RST),
      .en (EN),
      .i  (I[g]),
      .zn (ZN[g]),
      .chg(CHG[g])
    );
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__invflt_func.sv
// tb/tb_gf180mcu_fd_sc_mcu7t5v0__invflt_func.sv - vector table, latency sequence and random run against a sample-history model
`timescale 1ns/1ps
module tb_gf180mcu_fd_sc_mcu7t5v0__invflt_func;

  localparam int W = 4;
`ifdef GF180MCU_FD_SC_MCU7T5V0__INVFLT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic [W-1:0] i_in = '0;
  logic [W-1:0] zn3, chg3, zn1, chg1;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__invflt_func #(.WIDTH(W), .FILT_CYCLES(3)) dut3 (
    .CLK(clk), .RST(rst), .EN(en), .I(i_in), .ZN(zn3), .CHG(chg3)
  );

  gf180mcu_fd_sc_mcu7t5v0__invflt_func #(.WIDTH(W), .FILT_CYCLES(1)) dut1 (
    .CLK(clk), .RST(rst), .EN(en), .I(i_in), .ZN(zn1), .CHG(chg1)
  );

  typedef struct {
    logic         rst;
    logic         en;
    logic [W-1:0] i;
    logic [W-1:0] zn;
    logic [W-1:0] chg;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;

  // Model: ZN follows ~s once the last FILT enabled samples agree; reset seeds a run of zeros.
  int           filt[2] = '{3, 1};
  logic [7:0]   hist[2][W];
  logic [W-1:0] m_zn[2];
  logic [W-1:0] m_chg[2];
  logic [W-1:0] sp1, sp2;

  task automatic model_edge();
    logic [W-1:0] s;
    logic [7:0]   mask;
    logic [7:0]   win;
    s = (LAT == 2) ? sp2 : i_in;
    if (rst) begin
      sp1 = '0;
      sp2 = '0;
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < W; c++) hist[k][c] = 8'h00;
        m_zn[k]  = '1;
        m_chg[k] = '0;
      end
    end else begin
      sp2 = sp1;
      sp1 = i_in;
      for (int k = 0; k < 2; k++) begin
        m_chg[k] = '0;
        if (en) begin
          mask = 8'((1 << filt[k]) - 1);
          for (int c = 0; c < W; c++) begin
            hist[k][c] = {hist[k][c][6:0], s[c]};
            win = hist[k][c] & mask;
            if ((win == 8'h00 || win == mask) && (m_zn[k][c] != !s[c])) begin
              m_zn[k][c]  = !s[c];
              m_chg[k][c] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("zn filt3 vs model", zn3, m_zn[0]);
    check("chg filt3 vs model", chg3, m_chg[0]);
    check("zn filt1 vs model", zn1, m_zn[1]);
    check("chg filt1 vs model", chg1, m_chg[1]);
  endtask

  task automatic add(input logic r, input logic e, input logic [W-1:0] iv,
                     input logic [W-1:0] z, input logic [W-1:0] c);
    vec_t v;
    v.rst = r; v.en = e; v.i = iv; v.zn = z; v.chg = c;
    vecs.push_back(v);
  endtask

  int lat1, lat3;

  initial begin
    // reset, then quiet input
    add(1, 1, 4'b0101, 4'b1111, 4'b0000);
    add(1, 1, 4'b0101, 4'b1111, 4'b0000);
    add(0, 1, 4'b0000, 4'b1111, 4'b0000);
    add(0, 1, 4'b0000, 4'b1111, 4'b0000);
    // step on channel 0
    add(0, 1, 4'b0001, 4'b1111, 4'b0000);
    add(0, 1, 4'b0001, 4'b1111, 4'b0000);
    add(0, 1, 4'b0001, 4'b1110, 4'b0001);
    add(0, 1, 4'b0001, 4'b1110, 4'b0000);
    // two-sample glitch and alternating pattern on channel 1
    add(0, 1, 4'b0011, 4'b1110, 4'b0000);
    add(0, 1, 4'b0011, 4'b1110, 4'b0000);
    add(0, 1, 4'b0001, 4'b1110, 4'b0000);
    add(0, 1, 4'b0001, 4'b1110, 4'b0000);
    add(0, 1, 4'b0001, 4'b1110, 4'b0000);
    add(0, 1, 4'b0011, 4'b1110, 4'b0000);
    add(0, 1, 4'b0001, 4'b1110, 4'b0000);
    add(0, 1, 4'b0011, 4'b1110, 4'b0000);
    add(0, 1, 4'b0001, 4'b1110, 4'b0000);
    // channel 2 step frozen by EN after two samples
    add(0, 1, 4'b0101, 4'b1110, 4'b0000);
    add(0, 1, 4'b0101, 4'b1110, 4'b0000);
    for (int n = 0; n < 5; n++) add(0, 0, 4'b0000, 4'b1110, 4'b0000);
    add(0, 1, 4'b0101, 4'b1010, 4'b0100);
    add(0, 1, 4'b0101, 4'b1010, 4'b0000);
    // reset in the middle of a channel 3 rising step
    add(0, 1, 4'b1101, 4'b1010, 4'b0000);
    add(0, 1, 4'b1101, 4'b1010, 4'b0000);
    add(1, 1, 4'b1101, 4'b1111, 4'b0000);
    add(0, 1, 4'b1101, 4'b1111, 4'b0000);
    add(0, 1, 4'b1101, 4'b1111, 4'b0000);
    add(0, 1, 4'b1101, 4'b0010, 4'b1101);
    add(0, 1, 4'b1101, 4'b0010, 4'b0000);
    // reset wins over EN low, then a frozen edge
    add(1, 0, 4'b0000, 4'b1111, 4'b0000);
    add(0, 0, 4'b1111, 4'b1111, 4'b0000);

    foreach (vecs[j]) begin
      rst  = vecs[j].rst;
      en   = vecs[j].en;
      i_in = vecs[j].i;
      step();
`ifndef GF180MCU_FD_SC_MCU7T5V0__INVFLT_SYNC_EN
      check($sformatf("row%0d zn", j), zn3, vecs[j].zn);
      check($sformatf("row%0d chg", j), chg3, vecs[j].chg);
`endif
    end

    // step latency for FILT=3 and FILT=1, including synchronizer delay
    rst = 1; en = 1; i_in = '0;
    step();
    rst = 0;
    repeat (3) step();
    i_in = '1;
    lat1 = -1;
    lat3 = -1;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (lat1 < 0 && zn1 == '0) lat1 = e;
      if (lat3 < 0 && zn3 == '0) lat3 = e;
    end
    nvec++;
    if (lat1 != 1 + LAT) begin
      nerr++;
      $display("FAIL latency filt1: got %0d edges expected %0d", lat1, 1 + LAT);
    end
    nvec++;
    if (lat3 != 3 + LAT) begin
      nerr++;
      $display("FAIL latency filt3: got %0d edges expected %0d", lat3, 3 + LAT);
    end

    // random run with sticky per-channel levels
    rst = 1;
    step();
    rst = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < W; c++) begin
        if ($urandom_range(3) == 0) i_in[c] = ~i_in[c];
      end
      en  = ($urandom_range(7) != 0);
      rst = ($urandom_range(99) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
